// File: rtl/jtag_scan_engine.sv
// rtl/jtag_scan_engine.sv - JTAG master turning TAP reset / IR scan / DR scan requests into TCK/TMS/TDI waveforms
module jtag_scan_engine #(
  parameter int MAX_LEN = 64,
  parameter int CLK_DIV = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_reset_i,
  input  logic                         req_ir_i,
  input  logic [$clog2(MAX_LEN+1)-1:0] req_len_i,
  input  logic [MAX_LEN-1:0]           req_data_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [MAX_LEN-1:0]           rsp_data_o,
  output logic                         jtag_tck_o,
  output logic                         jtag_tms_o,
  output logic                         jtag_tdi_o,
  output logic                         jtag_trst_no,
  input  logic                         jtag_tdo_i
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, RST_SEQ, PRE, SHIFT, POST, RESP} state_t;

  state_t             state_q, state_d;
  logic [LW-1:0]      pcnt_q, pcnt_d, len_q;
  logic [DW-1:0]      div_q, div_d;
  logic [MAX_LEN-1:0] data_q, mask_q, mask_d, rsp_q, rsp_d;
  logic               ir_q;
  logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, trst_q, trst_d;
  logic               advance, accept;

  assign accept = req_valid_i && (state_q == IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    div_d   = div_q;
    tck_d   = tck_q;
    mask_d  = mask_q;
    rsp_d   = rsp_q;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          pcnt_d = '0;
          div_d  = '0;
          tck_d  = 1'b0;
          rsp_d  = '0;
          if (req_reset_i) begin
            state_d = RST_SEQ;
            advance = 1'b1;
          end else if (req_len_i == '0) begin
            state_d = RESP;
          end else begin
            state_d = PRE;
            advance = 1'b1;
          end
        end
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      RST_SEQ, PRE, SHIFT, POST: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DW'(1);
        end else if (!tck_q) begin
          // Rising TCK: TDO has been stable since the previous falling edge
          div_d = '0;
          tck_d = 1'b1;
          if (state_q == SHIFT && jtag_tdo_i) rsp_d = rsp_q | mask_q;
        end else begin
          div_d   = '0;
          tck_d   = 1'b0;
          advance = 1'b1;
          pcnt_d  = pcnt_q + LW'(1);
          case (state_q)
            RST_SEQ: if (pcnt_q == LW'(5)) begin
              state_d = RESP;
              advance = 1'b0;
            end
            PRE: if (pcnt_q == (ir_q ? LW'(3) : LW'(2))) begin
              state_d = SHIFT;
              pcnt_d  = '0;
              mask_d  = MAX_LEN'(1);
            end
            SHIFT: begin
              mask_d = mask_q << 1;
              if (pcnt_q == len_q - LW'(1)) begin
                state_d = POST;
                pcnt_d  = '0;
              end
            end
            POST: if (pcnt_q == LW'(1)) begin
              state_d = RESP;
              advance = 1'b0;
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    // TMS/TDI/TRST change only when a new TCK period begins (falling edge)
    tms_d  = tms_q;
    tdi_d  = tdi_q;
    trst_d = trst_q;
    if (state_d == IDLE || state_d == RESP) begin
      tms_d  = 1'b0;
      tdi_d  = 1'b0;
      trst_d = 1'b1;
    end else if (advance) begin
      tms_d  = 1'b0;
      tdi_d  = 1'b0;
      trst_d = 1'b1;
      case (state_d)
        RST_SEQ: begin
          tms_d  = (pcnt_d != LW'(5));
          trst_d = (pcnt_d != '0);
        end
        PRE:     tms_d = ir_q ? (pcnt_d <= LW'(1)) : (pcnt_d == '0);
        SHIFT: begin
          tms_d = (pcnt_d == len_q - LW'(1));
          tdi_d = |(data_q & mask_d);
        end
        POST:    tms_d = (pcnt_d == '0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
      div_q  <= '0;
      mask_q <= '0;
      rsp_q  <= '0;
      data_q <= '0;
      len_q  <= '0;
      ir_q   <= 1'b0;
      tck_q  <= 1'b0;
      tms_q  <= 1'b0;
      tdi_q  <= 1'b0;
      trst_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      div_q  <= div_d;
      mask_q <= mask_d;
      rsp_q  <= rsp_d;
      tck_q  <= tck_d;
      tms_q  <= tms_d;
      tdi_q  <= tdi_d;
      trst_q <= trst_d;
      if (accept) begin
        len_q  <= req_len_i;
        data_q <= req_data_i;
        ir_q   <= req_ir_i;
      end
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_data_o   = rsp_q;
  assign jtag_tck_o   = tck_q;
  assign jtag_tms_o   = tms_q;
  assign jtag_tdi_o   = tdi_q;
  assign jtag_trst_no = trst_q;

endmodule

// File: tb/tb_jtag_scan_engine.sv
// tb/tb_jtag_scan_engine.sv - self-checking bench for jtag_scan_engine against a behavioural TAP
module tb_jtag_scan_engine;

  localparam logic [31:0] IDCODE = 32'h1010_2001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // CLK_DIV=1 instance wired to the TAP model
  logic        req_valid, req_ready, req_reset, req_ir, rsp_valid, rsp_ready;
  logic [6:0]  req_len;
  logic [63:0] req_data, rsp_data;
  logic        tck, tms, tdi, trst_n, tdo;

  // CLK_DIV=3 instance with TDI looped back to TDO
  logic        req_valid3, req_ready3, req_reset3, req_ir3, rsp_valid3, rsp_ready3;
  logic [6:0]  req_len3;
  logic [63:0] req_data3, rsp_data3;
  logic        tck3, tms3, tdi3, trst3_n, tdo3;
  assign tdo3 = tdi3;

  jtag_scan_engine #(.MAX_LEN(64), .CLK_DIV(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_reset_i(req_reset),
    .req_ir_i(req_ir), .req_len_i(req_len), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .jtag_tck_o(tck), .jtag_tms_o(tms), .jtag_tdi_o(tdi), .jtag_trst_no(trst_n),
    .jtag_tdo_i(tdo)
  );

  jtag_scan_engine #(.MAX_LEN(64), .CLK_DIV(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_reset_i(req_reset3),
    .req_ir_i(req_ir3), .req_len_i(req_len3), .req_data_i(req_data3),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3), .rsp_data_o(rsp_data3),
    .jtag_tck_o(tck3), .jtag_tms_o(tms3), .jtag_tdi_o(tdi3), .jtag_trst_no(trst3_n),
    .jtag_tdo_i(tdo3)
  );

  int cyc = 0;
  int rises = 0;
  int trst_low = 0;
  logic [7:0] tms_hist = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!trst_n) trst_low <= trst_low + 1;

  // Behavioural TAP: 0=TLR 1=RTI 2=SelDR 3=CapDR 4=ShDR 5=Ex1DR 6=PauseDR 7=Ex2DR 8=UpDR
  // 9=SelIR 10=CapIR 11=ShIR 12=Ex1IR 13=PauseIR 14=Ex2IR 15=UpIR
  int          tap = 0;
  logic [4:0]  ir = 5'd1, ir_sr = '0;
  logic [31:0] dr_sr = '0;

  function automatic int tap_next(input int s, input logic m);
    case (s)
      0: return m ? 0 : 1;
      1: return m ? 2 : 1;
      2: return m ? 9 : 3;
      3, 4: return m ? 5 : 4;
      5: return m ? 8 : 6;
      6: return m ? 7 : 6;
      7: return m ? 8 : 4;
      9: return m ? 0 : 10;
      10, 11: return m ? 12 : 11;
      12: return m ? 15 : 13;
      13: return m ? 14 : 13;
      14: return m ? 15 : 11;
      default: return m ? 2 : 1;
    endcase
  endfunction

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tap <= 0;
      ir  <= 5'd1;
    end else begin
      case (tap)
        0:  ir <= 5'd1;
        3:  dr_sr <= (ir == 5'd1) ? IDCODE : 32'd0;
        4:  if (ir == 5'd1) dr_sr <= {tdi, dr_sr[31:1]};
            else dr_sr[0] <= tdi;
        10: ir_sr <= 5'b00001;
        11: ir_sr <= {tdi, ir_sr[4:1]};
        15: ir <= ir_sr;
        default: ;
      endcase
      tap <= tap_next(tap, tms);
    end
  end

  always @(posedge tck) begin
    rises    <= rises + 1;
    tms_hist <= {tms_hist[6:0], tms};
  end

  always @(negedge tck) tdo <= (tap == 4) ? dr_sr[0] : (tap == 11) ? ir_sr[0] : 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic r, input logic i_ir, input int len, input logic [63:0] d,
                      output int t0);
    int n;
    req_valid = 1'b1;
    req_reset = r;
    req_ir    = i_ir;
    req_len   = 7'(len);
    req_data  = d;
    n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_reset = ~r;
    req_ir    = ~i_ir;
    req_len   = 7'd3;
    req_data  = ~d;
  endtask

  task automatic recv(input int t0, output logic [63:0] d, output int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    lat = rsp_valid ? (cyc - t0) : -1;
    d = rsp_data;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        ir;
    int          len;
    logic [63:0] data;
    logic [63:0] exp;
    int          lat;
    int          n;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int t0, lat, r0, l0, n, bad;
    logic [63:0] d, d0;
    logic seen;

    vecs[0]  = '{1'b1, 1'b0, 0,  64'h0,                 64'h0,                 13,  6};
    vecs[1]  = '{1'b0, 1'b1, 5,  64'h01,                64'h01,                23,  11};
    vecs[2]  = '{1'b0, 1'b0, 32, 64'h0,                 64'h1010_2001,         75,  37};
    vecs[3]  = '{1'b0, 1'b0, 33, 64'h1,                 64'h1_1010_2001,       77,  38};
    vecs[4]  = '{1'b0, 1'b1, 5,  64'h1F,                64'h01,                23,  11};
    vecs[5]  = '{1'b0, 1'b0, 64, 64'hA5A5_A5A5_A5A5_A5A5, 64'h4B4B_4B4B_4B4B_4B4A, 139, 69};
    vecs[6]  = '{1'b0, 1'b0, 1,  64'h1,                 64'h0,                 13,  6};
    vecs[7]  = '{1'b0, 1'b0, 0,  64'hFF,                64'h0,                 1,   0};
    vecs[8]  = '{1'b0, 1'b0, 8,  64'h3C,                64'h78,                27,  13};
    vecs[9]  = '{1'b1, 1'b1, 0,  64'hFFFF,              64'h0,                 13,  6};
    vecs[10] = '{1'b0, 1'b0, 32, 64'h0,                 64'h1010_2001,         75,  37};

    rst_n = 1'b0;
    {req_valid, req_reset, req_ir, rsp_ready} = '0;
    req_len = '0; req_data = '0;
    {req_valid3, req_reset3, req_ir3, rsp_ready3} = '0;
    req_len3 = '0; req_data3 = '0;

    repeat (3) @(negedge clk);
    check("rst tck", 64'(tck), 64'd0);
    check("rst tms", 64'(tms), 64'd0);
    check("rst tdi", 64'(tdi), 64'd0);
    check("rst trst", 64'(trst_n), 64'd0);
    check("rst req_ready", 64'(req_ready), 64'd1);
    check("rst rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst rsp_data", rsp_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("trst after release", 64'(trst_n), 64'd1);
    check("ready after release", 64'(req_ready), 64'd1);

    // CLK_DIV=3, DR len 8: exact TCK phases and latency 1+13*6
    req_valid3 = 1'b1; req_len3 = 7'd8; req_data3 = 64'hC3;
    t0 = cyc;
    @(negedge clk);
    req_valid3 = 1'b0; req_data3 = 64'h0;
    bad = 0; n = 0;
    while (!rsp_valid3 && n < 300) begin
      if (tck3 !== (((cyc - t0 - 1) % 6) >= 3)) bad++;
      @(negedge clk);
      n++;
    end
    check("div3 tck shape", 64'(bad), 64'd0);
    check("div3 latency", 64'(rsp_valid3 ? cyc - t0 : -1), 64'd79);
    check("div3 loopback data", rsp_data3, 64'hC3);
    rsp_ready3 = 1'b1;
    @(negedge clk);
    rsp_ready3 = 1'b0;

    // Asynchronous reset in the middle of a 32-bit DR shift
    send(1'b0, 1'b0, 32, 64'hDEAD_BEEF, t0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst pins", 64'({tck, tms, tdi, trst_n, rsp_valid, req_ready}), 64'b000001);
    check("midrst rsp_data", rsp_data, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst ready", 64'(req_ready), 64'd1);
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("midrst no rsp", 64'(seen), 64'd0);

    for (int i = 0; i < 11; i++) begin
      r0 = rises;
      l0 = trst_low;
      send(vecs[i].rst, vecs[i].ir, vecs[i].len, vecs[i].data, t0);
      recv(t0, d, lat);
      check($sformatf("v%0d data", i), d, vecs[i].exp);
      check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d tck periods", i), 64'(rises - r0), 64'(vecs[i].n));
      check($sformatf("v%0d tap in rti", i), 64'(tap), 64'd1);
      if (vecs[i].rst) begin
        check($sformatf("v%0d reset tms", i), 64'(tms_hist[5:0]), 64'b111110);
        check($sformatf("v%0d trst low clks", i), 64'(trst_low - l0), 64'd2);
      end
    end

    // Response backpressure with a queued request
    send(1'b0, 1'b0, 8, 64'h0, t0);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp first valid", 64'(rsp_valid), 64'd1);
    d0 = rsp_data;
    req_valid = 1'b1; req_reset = 1'b0; req_ir = 1'b0; req_len = 7'd8; req_data = 64'h0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || req_ready !== 1'b0) bad++;
    end
    check("bp stable", 64'(bad), 64'd0);
    check("bp first data", d0, 64'h01);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp accept after rsp", 64'({req_ready, rsp_valid}), 64'b10);
    t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    recv(t0, d, lat);
    check("bp second data", d, 64'h01);
    check("bp second latency", 64'(lat), 64'd27);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
